mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Iterative multiply/divide unit with HI/LO result registers, parametrised in operand width.
//   Sits beside the single-cycle ALU in the MIPS datapath and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//   The controller starts an operation with a start/busy/done handshake and stalls the PC while busy=1.
//   HI/LO are architectural state, read combinationally for MFHI/MFLO.
// PARAMETERS
//   WIDTH    32   operand and HI/LO width in bits; must be >= 4 and even.
// PORTS
//   clk    in   1       clock; all state updates on posedge
//   rst    in   1       asynchronous, active-high reset
//   start  in   1       request; sampled on posedge, accepted only when busy=0
//   op     in   3       000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   srca   in   WIDTH   multiplicand / dividend / MTHI-MTLO source
//   srcb   in   WIDTH   multiplier / divisor
//   busy   out  1       iterative operation in flight
//   done   out  1       one-cycle pulse: HI/LO just updated
//   hi     out  WIDTH   HI register (product upper half / remainder)
//   lo     out  WIDTH   LO register (product lower half / quotient)
// BEHAVIOUR
//   - Reset (async, any time): busy=0, done=0, hi=0, lo=0; an in-flight operation is aborted, no done.
//   - Let E0 be the posedge where start=1 and busy=0. Each operation is accepted or ignored as a whole.
//   - MULT/MULTU/DIV/DIVU: at E0, capture operand magnitudes and result signs; busy=1 after E0.
//     One radix-2 step per edge at E1..E_WIDTH (shift-add multiply, restoring divide).
//     At E_WIDTH: write hi/lo, busy=0, done=1 for exactly one cycle. busy is high for WIDTH cycles.
//   - hi/lo hold their old values until E_WIDTH; partial results live in internal registers only.
//   - Signed ops run on magnitudes. At E_WIDTH: product negated if signs differ.
//     Quotient truncates toward zero. Remainder takes the sign of the dividend.
//   - Product: {hi,lo} = full 2*WIDTH result. Division: lo = quotient, hi = remainder.
//   - Divide by zero (DIV or DIVU): full WIDTH-cycle latency, then lo = all ones, hi = srca.
//   - DIV of the most-negative value by -1: lo = most-negative value, hi = 0.
//   - MTHI/MTLO: hi (resp. lo) <= srca at E0. busy stays 0; done=1 in the cycle after E0.
//   - op 11x with start=1: no state change, no done.
//   - start=1 while busy=1: ignored, no effect on the in-flight operation or its operands.
//   - start=1 in the done cycle (busy=0): accepted normally, new E0.
//   - FSM states:
//       IDLE -(start, mul/div op)-> RUN (counter=WIDTH)
//       RUN: decrement counter each edge; at counter==1 -> FIN
//       FIN: write hi/lo, pulse done -> IDLE
//     FIN must not add a cycle: hi/lo are written at E_WIDTH.
//   - Counter width is $clog2(WIDTH)+1. No wrap-around is permitted.
// CONFIGURATION
//   MDU_FAST_MUL_EN defined:
//     MULT/MULTU use a single-cycle WIDTHxWIDTH multiplier.
//     hi/lo are written at E0; busy stays 0; done=1 in the cycle after E0.
//     DIV/DIVU are unchanged (iterative).
//   MDU_FAST_MUL_EN undefined: all four arithmetic ops are iterative, WIDTH cycles, as above.
// TESTING
//   1. Reset, then MULTU srca=0xFFFFFFFF srcb=2 -> busy=1 for 32 cycles; hi=0x00000001, lo=0xFFFFFFFE, one done pulse.
//   2. MULT srca=0xFFFFFFFD (-3) srcb=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//      DIVU 100/7 -> lo=14, hi=2.
//      DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   3. DIVU 5/0 -> after 32 cycles lo=0xFFFFFFFF, hi=5.
//      DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   4. MTHI srca=0x1234 then MTLO srca=0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678.
//      busy never rises; two done pulses.
//   5. DIVU 100/7 started; at cycle 5 apply start with MULTU 3*3 -> ignored; result lo=14, hi=2.
//      Repeat, assert rst at cycle 10 -> busy=0, hi=lo=0, no done pulse.
//   6. MDU_FAST_MUL_EN defined, WIDTH=16: MULT 0x8000*0x8000 -> hi=0x4000, lo=0x0000.
//      done in the cycle after start; busy=0 throughout.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Define MDU_FAST_MUL_EN to perform MULT/MULTU in a single cycle; DIV/DIVU remain iterative.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  // {upper, lower} for multiply, {remainder, quotient} for divide
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_step, step;

`ifdef MDU_FAST_MUL_EN
  logic signed [2*WIDTH-1:0] fast_s;
  logic [2*WIDTH-1:0]        fast_u;
  assign fast_s = $signed({{WIDTH{srca[WIDTH-1]}}, srca}) * $signed({{WIDTH{srcb[WIDTH-1]}}, srcb});
  assign fast_u = {{WIDTH{1'b0}}, srca} * {{WIDTH{1'b0}}, srcb};
`endif

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;

    sgn_a = ~op[0] & srca[WIDTH-1];
    sgn_b = ~op[0] & srcb[WIDTH-1];
    mag_a = neg_w(srca, sgn_a);
    mag_b = neg_w(srcb, sgn_b);

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    // A borrow out of the trial subtraction means the shifted remainder is below the divisor
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    step      = is_div_q ? div_step : mul_step;

    case (state_q)
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
        // The last step and the HI/LO write share one edge, so FIN is the done cycle itself
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
          done_d  = 1'b1;
          if (is_div_q) begin
            lo_d = dz_q ? {WIDTH{1'b1}} : neg_w(step[WIDTH-1:0], neg_lo_q);
            hi_d = neg_w(step[2*WIDTH-1:WIDTH], neg_hi_q);
          end else begin
            {hi_d, lo_d} = neg_2w(step, neg_lo_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          if (!op[2]) begin
`ifdef MDU_FAST_MUL_EN
            if (!op[1]) begin
              {hi_d, lo_d} = op[0] ? fast_u : fast_s;
              done_d       = 1'b1;
            end else
`endif
            begin
              is_div_d = op[1];
              acc_d    = op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
              opnd_d   = op[1] ? mag_b : mag_a;
              neg_lo_d = sgn_a ^ sgn_b;
              neg_hi_d = sgn_a;
              dz_d     = (srcb == {WIDTH{1'b0}});
              state_d  = RUN;
              cnt_d    = CW'(WIDTH);
            end
          end else if (!op[1]) begin
            done_d = 1'b1;
            if (op[0]) lo_d = srca;
            else       hi_d = srca;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
    dz_q     <= dz_d;
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: 32-bit instance plus a 16-bit instance for the fast-multiply case.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] srca = '0, srcb = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start16 = 1'b0;
  logic [2:0]  op16 = 3'b000;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [15:0] hi16, lo16;

  int tests = 0;
  int fails = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_CYC = 0;
  localparam int MUL16_CYC = 0;
`else
  localparam int MUL_CYC = 32;
  localparam int MUL16_CYC = 16;
`endif

  mul_div_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mul_div_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .srca(a16), .srcb(b16),
    .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output bit held, output logic d_end, output logic d_after);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; held = 1'b1; cyc = 0;
    issue(o, a, b);
    while (busy === 1'b1 && cyc < 100) begin
      if (hi !== h0 || lo !== l0) held = 1'b0;
      cyc++;
      @(negedge clk);
    end
    d_end = done;
    @(negedge clk);
    d_after = done;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", lo); end
    rst = 1'b0;
  endtask

  task automatic test_multu;
    int cyc; bit held; logic de, da;
    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, cyc, held, de, da);
    tests++; if (cyc != MUL_CYC) begin fails++; $display("FAIL multu_busy_cycles got %0d want %0d", cyc, MUL_CYC); end
    tests++; if (!held) begin fails++; $display("FAIL multu_hilo_hold got changed want held"); end
    tests++; if (de !== 1'b1) begin fails++; $display("FAIL multu_done got %b want 1", de); end
    tests++; if (da !== 1'b0) begin fails++; $display("FAIL multu_done_pulse got %b want 0", da); end
    tests++; if (hi !== 32'h1) begin fails++; $display("FAIL multu_hi got %h want 00000001", hi); end
    tests++; if (lo !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_lo got %h want fffffffe", lo); end
  endtask

  task automatic test_signed;
    int cyc; bit held; logic de, da;
    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, cyc, held, de, da);
    tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    tests++; if (lo !== 32'hFFFF_FFF1) begin fails++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    run_op(3'b011, 32'd100, 32'd7, cyc, held, de, da);
    tests++; if (cyc != 32) begin fails++; $display("FAIL divu_cycles got %0d want 32", cyc); end
    tests++; if (!held) begin fails++; $display("FAIL divu_hilo_hold got changed want held"); end
    tests++; if (de !== 1'b1 || da !== 1'b0) begin fails++; $display("FAIL divu_done got %b%b want 10", de, da); end
    tests++; if (lo !== 32'd14) begin fails++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    tests++; if (hi !== 32'd2) begin fails++; $display("FAIL divu_hi got %h want 00000002", hi); end
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, cyc, held, de, da);
    tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo got %h want fffffffd", lo); end
    tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi got %h want ffffffff", hi); end
  endtask

  task automatic test_div_edge;
    int cyc; bit held; logic de, da;
    run_op(3'b011, 32'd5, 32'd0, cyc, held, de, da);
    tests++; if (cyc != 32) begin fails++; $display("FAIL divz_cycles got %0d want 32", cyc); end
    tests++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divz_lo got %h want ffffffff", lo); end
    tests++; if (hi !== 32'd5) begin fails++; $display("FAIL divz_hi got %h want 00000005", hi); end
    run_op(3'b010, 32'hFFFF_FFFB, 32'd0, cyc, held, de, da);
    tests++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sdivz_lo got %h want ffffffff", lo); end
    tests++; if (hi !== 32'hFFFF_FFFB) begin fails++; $display("FAIL sdivz_hi got %h want fffffffb", hi); end
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, cyc, held, de, da);
    tests++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL divovf_hi got %h want 00000000", hi); end
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk);
    start = 1'b1; op = 3'b100; srca = 32'h1234;
    @(negedge clk);
    tests++; if (busy !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL mthi_flags busy/done got %b%b want 01", busy, done); end
    tests++; if (hi !== 32'h1234) begin fails++; $display("FAIL mthi_hi got %h want 00001234", hi); end
    op = 3'b101; srca = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL mtlo_flags busy/done got %b%b want 01", busy, done); end
    tests++; if (lo !== 32'h5678 || hi !== 32'h1234) begin fails++; $display("FAIL mtlo_hilo got %h/%h want 00001234/00005678", hi, lo); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL mtlo_done_end got %b want 0", done); end
    issue(3'b110, 32'hDEAD_BEEF, 32'h1);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL noop_flags busy/done got %b%b want 00", busy, done); end
    tests++; if (hi !== 32'h1234 || lo !== 32'h5678) begin fails++; $display("FAIL noop_hilo got %h/%h want 00001234/00005678", hi, lo); end
  endtask

  task automatic test_ignore_start;
    int cyc;
    cyc = 0;
    issue(3'b011, 32'd100, 32'd7);
    while (busy === 1'b1 && cyc < 100) begin
      if (cyc == 4) begin start = 1'b1; op = 3'b001; srca = 32'd3; srcb = 32'd3; end
      if (cyc == 5) start = 1'b0;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    tests++; if (cyc != 32) begin fails++; $display("FAIL ignore_cycles got %0d want 32", cyc); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL ignore_done got %b want 1", done); end
    tests++; if (lo !== 32'd14 || hi !== 32'd2) begin fails++; $display("FAIL ignore_result got hi %h lo %h want 2/14", hi, lo); end
  endtask

  task automatic test_reset_abort;
    int pulses, busy_cnt;
    pulses = 0; busy_cnt = 0;
    issue(3'b011, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    tests++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL abort_hilo got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (busy === 1'b1) busy_cnt++;
    end
    tests++; if (pulses != 0 || busy_cnt != 0) begin fails++; $display("FAIL abort_quiet got done %0d busy %0d want 0/0", pulses, busy_cnt); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    cyc = 0;
    issue(3'b001, 32'd6, 32'd7);
    while (busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    tests++; if (done !== 1'b1 || lo !== 32'd42 || hi !== 32'd0) begin fails++; $display("FAIL b2b_first got done %b hi %h lo %h want 1/0/2a", done, hi, lo); end
    start = 1'b1; op = 3'b011; srca = 32'd100; srcb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    tests++; if (cyc != 32) begin fails++; $display("FAIL b2b_cycles got %0d want 32", cyc); end
    tests++; if (done !== 1'b1 || lo !== 32'd14 || hi !== 32'd2) begin fails++; $display("FAIL b2b_second got done %b hi %h lo %h want 1/2/e", done, hi, lo); end
  endtask

  task automatic test_fast_mul16;
    int cyc;
    cyc = 0;
    @(negedge clk);
    start16 = 1'b1; op16 = 3'b000; a16 = 16'h8000; b16 = 16'h8000;
    @(negedge clk);
    start16 = 1'b0;
    while (busy16 === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    tests++; if (cyc != MUL16_CYC) begin fails++; $display("FAIL mul16_busy_cycles got %0d want %0d", cyc, MUL16_CYC); end
    tests++; if (done16 !== 1'b1) begin fails++; $display("FAIL mul16_done got %b want 1", done16); end
    tests++; if (hi16 !== 16'h4000 || lo16 !== 16'h0000) begin fails++; $display("FAIL mul16_result got %h/%h want 4000/0000", hi16, lo16); end
    @(negedge clk);
    tests++; if (done16 !== 1'b0) begin fails++; $display("FAIL mul16_done_pulse got %b want 0", done16); end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_signed;
    test_div_edge;
    test_mthi_mtlo;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    test_fast_mul16;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
